// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_sub_pkg;

    // Control FSM states: wait for a request, shift WIDTH bits, present the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor: d = x - y - z, bo is the borrow out.
module fs_cell (
    input  logic x_i,
    input  logic y_i,
    input  logic z_i,
    output logic d_o,
    output logic bo_o
);

    // Difference and borrow of a single bit position.
    always_comb begin
        d_o  = x_i ^ y_i ^ z_i;
        bo_o = (~x_i & y_i) | (~(x_i ^ y_i) & z_i);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b - b_in, LSB first, one bit per clock.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             b_in_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_out_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sacc_q, sacc_d;
    logic             bor_q, bor_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             cell_d;
    logic             cell_bo;
    logic             last_bit;

    assign last_bit = (cnt_q == LastBit);

    fs_cell u_fs_cell (
        .x_i  (sa_q[0]),
        .y_i  (sb_q[0]),
        .z_i  (bor_q),
        .d_o  (cell_d),
        .bo_o (cell_bo)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: start only honoured in IDLE; SHIFT ends on the last bit.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        ready_o = (state_q == IDLE);
        busy_o  = (state_q == SHIFT);
        done_o  = (state_q == DONE);
    end

    // Datapath next-state: load operands on accept, shift one bit per SHIFT cycle.
    always_comb begin
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sacc_d   = sacc_q;
        bor_d    = bor_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    sa_d  = a_i;
                    sb_d  = b_i;
                    bor_d = b_in_i;
                    cnt_d = '0;
                end
            end
            SHIFT: begin
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                sacc_d = {cell_d, sacc_q[WIDTH-1:1]};
                bor_d  = cell_bo;
                cnt_d  = cnt_q + CntW'(1);
                // Result registers take the completed word on the same edge, so
                // they never expose a partially shifted value.
                if (last_bit) begin
                    diff_d   = {cell_d, sacc_q[WIDTH-1:1]};
                    borrow_d = cell_bo;
                end
            end
            default: ;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            sacc_q   <= '0;
            bor_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sacc_q   <= sacc_d;
            bor_q    <= bor_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign diff_o       = diff_q;
    assign borrow_out_o = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8) with directed vectors.
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] d;
        logic       b;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic       b_in_i;
    logic       ready_o;
    logic       busy_o;
    logic       done_o;
    logic [7:0] diff_o;
    logic       borrow_out_o;

    int   checks;
    int   errors;
    int   cyc;
    logic done_prev;
    exp_t exp_q[$];
    int   done_times[$];

    serial_subtractor #(
        .WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .b_in_i       (b_in_i),
        .ready_o      (ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .diff_o       (diff_o),
        .borrow_out_o (borrow_out_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop the scoreboard whenever the DUT signals a result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done_o) begin
            done_times.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no result", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("diff", {24'd0, diff_o}, {24'd0, e.d});
                chk("borrow_out", {31'd0, borrow_out_o}, {31'd0, e.b});
            end
            if (done_prev) chk("done_pulse_width", 32'd1, 32'd0);
        end
        done_prev = done_o;
    end

    // Drive one request in an IDLE cycle; returns #1 after the accept edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input logic push, input logic [7:0] ed, input logic eb);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) chk("ready_timeout", 32'd0, 32'd1);
        a_i     = a;
        b_i     = b;
        b_in_i  = bin;
        start_i = 1'b1;
        if (push) exp_q.push_back('{d: ed, b: eb});
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d results pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        done_prev = 1'b0;
        start_i   = 1'b0;
        a_i       = '0;
        b_i       = '0;
        b_in_i    = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_diff", {24'd0, diff_o}, 32'd0);
        chk("rst_borrow", {31'd0, borrow_out_o}, 32'd0);
        rst_n = 1'b1;

        // Basic op plus latency and pulse width.
        issue(8'h5A, 8'h3C, 1'b0, 1'b1, 8'h1E, 1'b0);
        chk("busy_after_accept", {31'd0, busy_o}, 32'd1);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done_o) begin
                k = i;
                break;
            end
        end
        chk("done_latency_edges", k, 32'd8);
        @(posedge clk);
        #1;
        chk("done_single_cycle", {31'd0, done_o}, 32'd0);
        chk("ready_after_done", {31'd0, ready_o}, 32'd1);
        drain("drain_basic");

        // Boundary vectors.
        issue(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1);
        drain("drain_underflow");
        issue(8'h80, 8'h80, 1'b1, 1'b1, 8'hFF, 1'b1);
        drain("drain_equal_bin");
        issue(8'hFF, 8'h00, 1'b1, 1'b1, 8'hFE, 1'b0);
        drain("drain_max_bin");

        // Start during SHIFT is ignored; busy holds through edge 8.
        issue(8'h33, 8'h11, 1'b0, 1'b1, 8'h22, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) begin
                start_i = 1'b1;
                a_i     = 8'hFF;
                b_i     = 8'h00;
                b_in_i  = 1'b0;
            end
            if (i == 3) start_i = 1'b0;
            if (i < 8) chk($sformatf("busy_edge%0d", i), {31'd0, busy_o}, 32'd1);
            else chk("done_edge8", {31'd0, done_o}, 32'd1);
        end
        repeat (12) @(posedge clk);
        #1;
        chk("idle_after_ignored", {31'd0, ready_o}, 32'd1);
        drain("drain_ignored");

        // Reset mid-SHIFT aborts.
        issue(8'h44, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, ready_o}, 32'd1);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_done", {31'd0, done_o}, 32'd0);
        chk("abort_diff", {24'd0, diff_o}, 32'd0);
        chk("abort_borrow", {31'd0, borrow_out_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        issue(8'h44, 8'h11, 1'b0, 1'b1, 8'h33, 1'b0);
        drain("drain_after_abort");

        // Start held high: back-to-back ops WIDTH+2 cycles apart.
        done_times.delete();
        @(negedge clk);
        a_i     = 8'h10;
        b_i     = 8'h01;
        b_in_i  = 1'b0;
        start_i = 1'b1;
        exp_q.push_back('{d: 8'h0F, b: 1'b0});
        exp_q.push_back('{d: 8'hFF, b: 1'b1});
        @(posedge clk);
        #1;
        a_i = 8'h01;
        b_i = 8'h02;
        k = 0;
        @(negedge clk);
        while (!ready_o && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
        drain("drain_held_start");
        chk("held_done_count", done_times.size(), 32'd2);
        if (done_times.size() >= 2)
            chk("held_done_spacing", done_times[1] - done_times[0], 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
